// File: rtl/v_lane_sequencer.sv
// Sequences an LMUL-slice vector operation over G physical lane groups,
// issuing one pass at a time and assembling the returned slices into result.
module v_lane_sequencer #(
   parameter int unsigned VLEN       = 128,
   parameter int unsigned MAX_GROUPS = 4,
   parameter int unsigned MAX_LMUL   = 4
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       start,
   input  logic [1:0]                 lmul,
   input  logic [1:0]                 groups,
   input  logic [MAX_LMUL*VLEN-1:0]   op_a,
   input  logic [MAX_LMUL*VLEN-1:0]   op_b,
   output logic                       busy,
   output logic                       iss_valid,
   input  logic                       iss_ready,
   output logic [MAX_GROUPS*VLEN-1:0] iss_a,
   output logic [MAX_GROUPS*VLEN-1:0] iss_b,
   output logic [MAX_GROUPS-1:0]      iss_mask,
   input  logic                       res_valid,
   input  logic [MAX_GROUPS*VLEN-1:0] res_data,
   output logic [MAX_LMUL*VLEN-1:0]   result,
   output logic                       done,
   output logic                       err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t                   state, state_next;
   logic [MAX_LMUL*VLEN-1:0] a_reg, b_reg;
   int unsigned              lmul_reg, grp_reg, pass_reg;
   int unsigned              lmul_cnt, grp_cnt;
   int unsigned              slice_idx [MAX_GROUPS];
   logic [MAX_GROUPS-1:0]    active;
   logic                     cfg_bad, last_pass, accept, capture;
   logic                     err_reg;

   always_comb begin
      lmul_cnt = 32'd1 << lmul;
      grp_cnt  = 32'd1 << groups;
      cfg_bad  = (lmul == 2'b11) || (groups == 2'b11) ||
                 (lmul_cnt > MAX_LMUL) || (grp_cnt > MAX_GROUPS);
      accept   = (state == IDLE) && start && !cfg_bad;
      capture  = (state == WAIT) && res_valid;
      last_pass = ((pass_reg + 32'd1) * grp_reg) >= lmul_reg;
   end

   // Group g of pass p works on slice p*G+g; slices past LMUL leave the group idle.
   always_comb begin
      active = '0;
      for (int unsigned g = 0; g < MAX_GROUPS; g++) begin
         slice_idx[g] = pass_reg * grp_reg + g;
         if ((g < grp_reg) && (slice_idx[g] < lmul_reg))
            active[g] = 1'b1;
      end
   end

   always_comb begin
      iss_a = '0;
      iss_b = '0;
      if (state == ISSUE) begin
         for (int unsigned g = 0; g < MAX_GROUPS; g++) begin
            for (int unsigned s = 0; s < MAX_LMUL; s++) begin
               if (active[g] && (slice_idx[g] == s)) begin
                  iss_a[g*VLEN +: VLEN] = a_reg[s*VLEN +: VLEN];
                  iss_b[g*VLEN +: VLEN] = b_reg[s*VLEN +: VLEN];
               end
            end
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = ISSUE;
         ISSUE:   if (iss_ready) state_next = WAIT;
         WAIT:    if (res_valid) state_next = last_pass ? DONE : ISSUE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         a_reg    <= '0;
         b_reg    <= '0;
         lmul_reg <= 0;
         grp_reg  <= 0;
         pass_reg <= 0;
         result   <= '0;
         err_reg  <= 1'b0;
      end else begin
         state   <= state_next;
         err_reg <= (state == IDLE) && start && cfg_bad;
         if (accept) begin
            a_reg    <= op_a;
            b_reg    <= op_b;
            lmul_reg <= lmul_cnt;
            grp_reg  <= grp_cnt;
            pass_reg <= 0;
            result   <= '0;
         end
         if (capture) begin
            for (int unsigned s = 0; s < MAX_LMUL; s++) begin
               for (int unsigned g = 0; g < MAX_GROUPS; g++) begin
                  if (active[g] && (slice_idx[g] == s))
                     result[s*VLEN +: VLEN] <= res_data[g*VLEN +: VLEN];
               end
            end
            if (!last_pass)
               pass_reg <= pass_reg + 32'd1;
         end
      end
   end

   assign busy      = (state != IDLE);
   assign iss_valid = (state == ISSUE);
   assign iss_mask  = (state == ISSUE) ? active : '0;
   assign done      = (state == DONE);
   assign err       = err_reg;

endmodule

// File: tb/tb_v_lane_sequencer.sv
// Directed bench for v_lane_sequencer; the bench plays the FU array as an adder
// with one cycle of latency and checks against hand-computed slice sums.
module tb_v_lane_sequencer;

   localparam int VLEN = 128;

   localparam logic [127:0] Z    = 128'h0;
   localparam logic [127:0] A0   = {4{32'h11111111}};
   localparam logic [127:0] A1   = {4{32'h22222222}};
   localparam logic [127:0] A2   = {4{32'h33333333}};
   localparam logic [127:0] A3   = {4{32'h44444444}};
   localparam logic [127:0] B0   = {4{32'h01010101}};
   localparam logic [127:0] S0   = {4{32'h12121212}};
   localparam logic [127:0] S1   = {4{32'h23232323}};
   localparam logic [127:0] S2   = {4{32'h34343434}};
   localparam logic [127:0] S3   = {4{32'h45454545}};
   localparam logic [127:0] JUNK = {4{32'hDEADBEEF}};

   logic         clk = 1'b0;
   logic         nrst = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   lmul = 2'b00;
   logic [1:0]   groups = 2'b00;
   logic [511:0] op_a = '0;
   logic [511:0] op_b = '0;
   logic         busy, iss_valid, done, err;
   logic         iss_ready = 1'b0;
   logic [511:0] iss_a, iss_b, result;
   logic [3:0]   iss_mask;
   logic         res_valid = 1'b0;
   logic [511:0] res_data = '0;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int start_cyc = 0;

   v_lane_sequencer #(.VLEN(128), .MAX_GROUPS(4), .MAX_LMUL(4)) dut (
      .clk(clk), .nrst(nrst), .start(start), .lmul(lmul), .groups(groups),
      .op_a(op_a), .op_b(op_b), .busy(busy), .iss_valid(iss_valid),
      .iss_ready(iss_ready), .iss_a(iss_a), .iss_b(iss_b), .iss_mask(iss_mask),
      .res_valid(res_valid), .res_data(res_data), .result(result),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".busy"}, busy, 0);
      check({tag, ".done"}, done, 0);
      check({tag, ".err"}, err, 0);
      check({tag, ".iss_valid"}, iss_valid, 0);
      check({tag, ".iss_mask"}, iss_mask, 0);
      check({tag, ".iss_a"}, iss_a, 0);
      check({tag, ".iss_b"}, iss_b, 0);
      check({tag, ".result"}, result, 0);
   endtask

   task automatic start_op(input logic [1:0] l, input logic [1:0] g);
      lmul = l;
      groups = g;
      op_a = {A3, A2, A1, A0};
      op_b = {B0, B0, B0, B0};
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   // One pass: optional ready stall, handshake, one cycle of FU latency, response.
   task automatic do_pass(input string tag, input logic [3:0] exp_mask,
                          input logic [511:0] exp_a, input logic [511:0] exp_b,
                          input int hold);
      logic [511:0] sum_v;
      for (int h = 0; h < hold; h++) begin
         check({tag, ".hold_valid"}, iss_valid, 1);
         check({tag, ".hold_mask"}, iss_mask, exp_mask);
         check({tag, ".hold_a"}, iss_a, exp_a);
         check({tag, ".hold_b"}, iss_b, exp_b);
         res_valid = (h == 2);
         res_data = {4{JUNK}};
         @(negedge clk);
      end
      res_valid = 1'b0;
      if (hold > 0) check({tag, ".stray_issue"}, result, 0);
      check({tag, ".busy"}, busy, 1);
      check({tag, ".iss_valid"}, iss_valid, 1);
      check({tag, ".iss_mask"}, iss_mask, exp_mask);
      check({tag, ".iss_a"}, iss_a, exp_a);
      check({tag, ".iss_b"}, iss_b, exp_b);
      for (int g = 0; g < 4; g++)
         sum_v[g*VLEN +: VLEN] = exp_mask[g] ?
            exp_a[g*VLEN +: VLEN] + exp_b[g*VLEN +: VLEN] : JUNK;
      iss_ready = 1'b1;
      @(negedge clk);
      iss_ready = 1'b0;
      check({tag, ".wait_valid"}, iss_valid, 0);
      @(negedge clk);
      res_valid = 1'b1;
      res_data = sum_v;
      @(negedge clk);
      res_valid = 1'b0;
      res_data = '0;
   endtask

   task automatic finish_op(input string tag, input logic [511:0] exp_res, input int exp_lat);
      check({tag, ".done"}, done, 1);
      check({tag, ".busy_done"}, busy, 1);
      check({tag, ".latency"}, cyc - start_cyc, exp_lat);
      check({tag, ".result"}, result, exp_res);
      @(negedge clk);
      check({tag, ".done_off"}, done, 0);
      check({tag, ".busy_off"}, busy, 0);
      res_valid = 1'b1;
      res_data = {4{JUNK}};
      @(negedge clk);
      res_valid = 1'b0;
      res_data = '0;
      check({tag, ".stray_idle"}, result, exp_res);
   endtask

   initial begin
      $display("[TB] start");
      repeat (2) @(negedge clk);
      check_idle_outputs("reset");
      nrst = 1'b1;
      @(negedge clk);

      start_op(2'b00, 2'b00);
      do_pass("t1p0", 4'b0001, {Z, Z, Z, A0}, {Z, Z, Z, B0}, 0);
      finish_op("t1", {Z, Z, Z, S0}, 4);

      start_op(2'b10, 2'b00);
      do_pass("t2p0", 4'b0001, {Z, Z, Z, A0}, {Z, Z, Z, B0}, 0);
      do_pass("t2p1", 4'b0001, {Z, Z, Z, A1}, {Z, Z, Z, B0}, 0);
      do_pass("t2p2", 4'b0001, {Z, Z, Z, A2}, {Z, Z, Z, B0}, 0);
      do_pass("t2p3", 4'b0001, {Z, Z, Z, A3}, {Z, Z, Z, B0}, 0);
      finish_op("t2", {S3, S2, S1, S0}, 13);

      start_op(2'b00, 2'b10);
      do_pass("t3p0", 4'b0001, {Z, Z, Z, A0}, {Z, Z, Z, B0}, 0);
      finish_op("t3", {Z, Z, Z, S0}, 4);

      start_op(2'b10, 2'b01);
      do_pass("t4p0", 4'b0011, {Z, Z, A1, A0}, {Z, Z, B0, B0}, 0);
      do_pass("t4p1", 4'b0011, {Z, Z, A3, A2}, {Z, Z, B0, B0}, 0);
      finish_op("t4", {S3, S2, S1, S0}, 7);

      start_op(2'b00, 2'b00);
      do_pass("t5p0", 4'b0001, {Z, Z, Z, A0}, {Z, Z, Z, B0}, 5);
      finish_op("t5", {Z, Z, Z, S0}, 9);

      lmul = 2'b11;
      groups = 2'b00;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("err_lmul.err", err, 1);
      check("err_lmul.busy", busy, 0);
      @(negedge clk);
      check("err_lmul.err_off", err, 0);
      check("err_lmul.busy_off", busy, 0);
      lmul = 2'b00;
      groups = 2'b11;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("err_grp.err", err, 1);
      check("err_grp.busy", busy, 0);
      @(negedge clk);

      start_op(2'b10, 2'b00);
      do_pass("t6p0", 4'b0001, {Z, Z, Z, A0}, {Z, Z, Z, B0}, 0);
      iss_ready = 1'b1;
      @(negedge clk);
      iss_ready = 1'b0;
      check("t6.partial", result, {Z, Z, Z, S0});
      check("t6.busy_wait", busy, 1);
      nrst = 1'b0;
      #1;
      check_idle_outputs("midreset");
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      check("postreset.done", done, 0);
      check("postreset.busy", busy, 0);

      start_op(2'b00, 2'b00);
      do_pass("t7p0", 4'b0001, {Z, Z, Z, A0}, {Z, Z, Z, B0}, 0);
      finish_op("t7", {Z, Z, Z, S0}, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/v_lane_sequencer.md
V_LANE_SEQUENCER -- requirements
Module: v_lane_sequencer

Interface
REQ-001 SHALL have parameter VLEN, default 128; bits per vector register slice and per lane group.
REQ-002 SHALL have parameter MAX_GROUPS, default 4; physical lane groups (power of two).
REQ-003 SHALL have parameter MAX_LMUL, default 4; maximum register-group multiplier (power of two).
REQ-004 SHALL have one clock, clk (rising edge), and reset nrst, asynchronous and active-low.
REQ-005 Ports SHALL be exactly:
- clk  in  1  clock
- nrst  in  1  async active-low reset
- start  in  1  request; sampled in IDLE only
- lmul  in  2  00=1, 01=2, 10=4, 11=reserved
- groups  in  2  active lane groups; 00=1, 01=2, 10=4, 11=reserved
- op_a  in  MAX_LMUL*VLEN  operand A slices; slice s = bits [s*VLEN +: VLEN]
- op_b  in  MAX_LMUL*VLEN  operand B slices
- busy  out  1  high when not IDLE
- iss_valid  out  1  issue request to FU array
- iss_ready  in  1  FU array accepts issue
- iss_a  out  MAX_GROUPS*VLEN  operand A per group g at [g*VLEN +: VLEN]
- iss_b  out  MAX_GROUPS*VLEN  operand B per group
- iss_mask  out  MAX_GROUPS  group g active this pass
- res_valid  in  1  FU results valid
- res_data  in  MAX_GROUPS*VLEN  results per group
- result  out  MAX_LMUL*VLEN  assembled result slices
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle reserved/unsupported-config pulse

Function
REQ-006 SHALL treat a config as invalid when lmul=11, groups=11, LMUL>MAX_LMUL or G>MAX_GROUPS.
REQ-007 FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-008 In IDLE, start=1 with valid config SHALL latch op_a, op_b, LMUL, G, clear result to 0, set pass=0, and enter ISSUE next cycle.
REQ-009 In IDLE, start=1 with invalid config SHALL pulse err for the next cycle only and remain in IDLE.
REQ-010 Pass count SHALL be P = max(1, LMUL/G); in pass p, group g SHALL handle slice s = p*G+g, active iff g<G and s<LMUL.
REQ-011 In ISSUE, iss_valid=1; iss_a/iss_b group g SHALL carry latched slice s when active, else zero; iss_mask SHALL flag active groups.
REQ-012 iss_valid, iss_a, iss_b and iss_mask SHALL hold stable until iss_ready=1; the handshake cycle SHALL move the FSM to WAIT.
REQ-013 In WAIT, res_valid=1 SHALL write res_data group g into result slice s for every active group; inactive slices SHALL stay unchanged.
REQ-014 On that capture, the FSM SHALL enter DONE if p=P-1, else increment p and enter ISSUE.
REQ-015 res_valid outside WAIT SHALL be ignored.
REQ-016 DONE SHALL assert done for exactly one cycle and return to IDLE; start SHALL be ignored in ISSUE, WAIT and DONE.
REQ-017 result SHALL hold its value from DONE until the next accepted start.
REQ-018 With iss_ready tied 1 and FU latency k cycles after handshake, done SHALL assert P*(k+2)+1 cycles after the start cycle.
REQ-019 busy SHALL be 1 in ISSUE, WAIT and DONE.

Reset
REQ-020 nrst=0 SHALL asynchronously force IDLE, p=0, and all outputs to 0, including result, busy, done, err and iss_*.
REQ-021 Reset asserted mid-operation SHALL abandon the operation without a done pulse; the first post-reset start SHALL behave as from power-up.

Verification
REQ-022 lmul=00, groups=00, op_a slice0=32'h1 x4, FU adds, k=1, ready=1 -> one issue with iss_mask=0001; result[127:0]=sum; done at cycle 4.
REQ-023 lmul=10, groups=00 -> 4 passes, iss_mask=0001 each, slices 0..3 filled in order; done at cycle 13 (k=1).
REQ-024 lmul=10, groups=01 -> 2 passes; pass0 slices 0,1, pass1 slices 2,3; iss_mask=0011 both passes.
REQ-025 lmul=00, groups=10 -> 1 pass with iss_mask=0001; groups 1-3 zero on iss_a/iss_b; result slices 1-3 = 0.
REQ-026 iss_ready held 0 for 5 cycles in ISSUE -> iss_* stable for all 5 cycles; stray res_valid pulses in ISSUE and IDLE leave result unchanged.
REQ-027 lmul=11 start -> err=1 for one cycle, busy stays 0; nrst pulsed in WAIT during a 4-pass op -> all outputs 0 immediately, no done, next op correct.
